// File: rtl/dmem_lsu.sv
// dmem_lsu: single-port data memory with a load/store unit front end.
// One request is accepted per cycle when the response slot is free or is
// being drained on the same edge. Loads read the word array asynchronously
// at the acceptance edge, so the response register holds the extended load
// data one cycle later. Stores write the addressed byte lanes on the
// acceptance edge. Misaligned or illegal requests are rejected with rsp_err,
// leave memory untouched and bump a saturating error counter.
module dmem_lsu #(
  parameter int ADDR_W    = 15,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_memop,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int WORD_AW   = ADDR_W - 2;
  localparam int MEM_DEPTH = 2 ** WORD_AW;

  // Memory operation encodings
  localparam logic [2:0] MOP_BS = 3'd0;
  localparam logic [2:0] MOP_HS = 3'd1;
  localparam logic [2:0] MOP_W  = 3'd2;
  localparam logic [2:0] MOP_BU = 3'd4;
  localparam logic [2:0] MOP_HU = 3'd5;

  // Word storage; intentionally not reset
  logic [31:0] mem_r [MEM_DEPTH];

  // Response and counter state
  logic                 rsp_valid_r;
  logic [31:0]          rsp_rdata_r;
  logic                 rsp_err_r;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Request decode
  logic [WORD_AW-1:0] word_idx_s;
  logic [1:0]         lane_off_s;
  logic               accept_s;
  logic               illegal_s;
  logic               wr_en_s;
  logic [3:0]         byte_en_s;
  logic [31:0]        wr_lanes_s;
  logic [31:0]        rd_word_s;
  logic [7:0]         rd_byte_s;
  logic [15:0]        rd_half_s;
  logic [31:0]        load_data_s;
  logic [31:0]        rsp_data_nxt_s;

  assign word_idx_s = req_addr[ADDR_W-1:2];
  assign lane_off_s = req_addr[1:0];

  // A pending response blocks new requests unless it drains on this edge.
  // Gating with rst_n keeps req_ready high in reset but blocks acceptance.
  assign req_ready = !rsp_valid_r || rsp_ready;
  assign accept_s  = req_valid && req_ready && rst_n;
  assign wr_en_s   = accept_s && req_we && !illegal_s;

  // Legality check: unsupported encodings, unsigned stores, misalignment
  always_comb begin
    illegal_s = 1'b1;
    case (req_memop)
      MOP_BS:  illegal_s = 1'b0;
      MOP_HS:  illegal_s = req_addr[0];
      MOP_W:   illegal_s = (lane_off_s != 2'b00);
      MOP_BU:  illegal_s = req_we;
      MOP_HU:  illegal_s = req_we || req_addr[0];
      default: illegal_s = 1'b1;
    endcase
  end

  // Byte enables and lane-replicated store data, little-endian placement
  always_comb begin
    byte_en_s  = 4'b0000;
    wr_lanes_s = 32'h0000_0000;
    case (req_memop[1:0])
      2'b00: begin
        byte_en_s  = 4'b0001 << lane_off_s;
        wr_lanes_s = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        if (lane_off_s[1]) begin
          byte_en_s = 4'b1100;
        end else begin
          byte_en_s = 4'b0011;
        end
        wr_lanes_s = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        byte_en_s  = 4'b1111;
        wr_lanes_s = req_wdata;
      end
      default: begin
        byte_en_s  = 4'b0000;
        wr_lanes_s = 32'h0000_0000;
      end
    endcase
  end

  // Lane selection for loads
  assign rd_word_s = mem_r[word_idx_s];
  assign rd_byte_s = rd_word_s[{lane_off_s, 3'b000} +: 8];
  assign rd_half_s = lane_off_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

  // Sign/zero extension of the selected lanes
  always_comb begin
    load_data_s = 32'h0000_0000;
    case (req_memop)
      MOP_BS:  load_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
      MOP_BU:  load_data_s = {24'h00_0000, rd_byte_s};
      MOP_HS:  load_data_s = {{16{rd_half_s[15]}}, rd_half_s};
      MOP_HU:  load_data_s = {16'h0000, rd_half_s};
      MOP_W:   load_data_s = rd_word_s;
      default: load_data_s = 32'h0000_0000;
    endcase
  end

  // Stores and rejected requests return zero data
  always_comb begin
    rsp_data_nxt_s = 32'h0000_0000;
    if (req_we || illegal_s) begin
      rsp_data_nxt_s = 32'h0000_0000;
    end else begin
      rsp_data_nxt_s = load_data_s;
    end
  end

  // Byte-lane write port; only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wr_lanes_s[8*i +: 8];
        end
      end
    end
  end

  // Single response slot: load on acceptance, clear on drain, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_rdata_r <= rsp_data_nxt_s;
      rsp_err_r   <= illegal_s;
    end else if (rsp_ready) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Saturating count of rejected requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= {ERR_CNT_W{1'b0}};
    end else if (accept_s && illegal_s && (err_cnt_r != {ERR_CNT_W{1'b1}})) begin
      err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu. Each accepted request pushes its expected
// {err, rdata} to a queue; a negedge monitor pops and compares whenever a
// response is consumed. Extra checks cover reset, stall, and err_cnt.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_memop;
  logic [14:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_errcnt = 0;
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;

  dmem_lsu #(.ADDR_W(15), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_memop (req_memop),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each consumed response against the oldest expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e[32]});
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, record expectation
  task automatic do_req(input logic we, input logic [2:0] op, input logic [14:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee);
    bit ok = 1'b0;
    req_we = we; req_memop = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        exp_q.push_back({ee, er});
        ok = 1'b1;
      end
    end
    if (!ok) begin
      chk("req_timeout", {31'b0, req_ready}, 32'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rsp_latency", {31'b0, rsp_valid}, 32'd1);
      if (ee && exp_errcnt < 255) exp_errcnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_we = 1'b0; req_memop = 3'd0; req_addr = 15'h0; req_wdata = 32'h0;
    #3;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("reset_err_cnt", {24'b0, err_cnt}, 32'd0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    idle(1);

    // Word store then signed/unsigned byte loads
    do_req(1'b1, 3'd2, 15'h0010, 32'h8000_00F1, 32'h0, 1'b0);
    do_req(1'b0, 3'd0, 15'h0010, 32'h0,         32'hFFFF_FFF1, 1'b0);
    do_req(1'b0, 3'd4, 15'h0010, 32'h0,         32'h0000_00F1, 1'b0);

    // Byte/half lane merging
    do_req(1'b1, 3'd2, 15'h0010, 32'h1122_3344, 32'h0, 1'b0);
    do_req(1'b1, 3'd0, 15'h0013, 32'hFFFF_FFAB, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 15'h0010, 32'h0,         32'hAB22_3344, 1'b0);
    do_req(1'b0, 3'd5, 15'h0012, 32'h0,         32'h0000_AB22, 1'b0);
    do_req(1'b0, 3'd1, 15'h0012, 32'h0,         32'hFFFF_AB22, 1'b0);
    do_req(1'b0, 3'd0, 15'h0011, 32'h0,         32'h0000_0033, 1'b0);
    do_req(1'b1, 3'd1, 15'h0010, 32'h1234_BEEF, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 15'h0010, 32'h0,         32'hAB22_BEEF, 1'b0);
    do_req(1'b0, 3'd1, 15'h0010, 32'h0,         32'hFFFF_BEEF, 1'b0);

    // Rejections leave memory untouched and count up
    do_req(1'b1, 3'd2, 15'h0000, 32'h5566_7788, 32'h0, 1'b0);
    idle(2);
    chk("err_cnt_before", {24'b0, err_cnt}, 32'd0);
    do_req(1'b0, 3'd2, 15'h0006, 32'h0,         32'h0, 1'b1);
    do_req(1'b1, 3'd4, 15'h0000, 32'h0000_00FF, 32'h0, 1'b1);
    idle(2);
    chk("err_cnt_two", {24'b0, err_cnt}, 32'd2);
    do_req(1'b0, 3'd2, 15'h0000, 32'h0,         32'h5566_7788, 1'b0);
    do_req(1'b0, 3'd3, 15'h0000, 32'h0,         32'h0, 1'b1);
    do_req(1'b0, 3'd1, 15'h0001, 32'h0,         32'h0, 1'b1);
    do_req(1'b1, 3'd1, 15'h0003, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req(1'b1, 3'd6, 15'h0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    do_req(1'b0, 3'd2, 15'h0000, 32'h0,         32'h5566_7788, 1'b0);
    idle(2);
    chk("err_cnt_six", {24'b0, err_cnt}, exp_errcnt);

    // Back-pressure: response held, no second acceptance, then back-to-back
    rsp_ready = 1'b0;
    do_req(1'b0, 3'd2, 15'h0000, 32'h0, 32'h5566_7788, 1'b0);
    req_we = 1'b0; req_memop = 3'd2; req_addr = 15'h0010; req_wdata = 32'h0; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
      chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'h5566_7788);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    exp_q.push_back({1'b0, 32'hAB22_BEEF});
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    idle(2);

    // Reset with a pending response and a store presented
    do_req(1'b1, 3'd2, 15'h0020, 32'hCAFE_BABE, 32'h0, 1'b0);
    idle(2);
    rsp_ready = 1'b0;
    req_we = 1'b0; req_memop = 3'd2; req_addr = 15'h0020; req_valid = 1'b1;
    @(negedge clk);
    chk("pre_rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    req_we = 1'b1; req_memop = 3'd2; req_addr = 15'h0020; req_wdata = 32'hDEAD_DEAD;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b1;
    exp_errcnt = 0;
    idle(1);
    do_req(1'b0, 3'd2, 15'h0020, 32'h0, 32'hCAFE_BABE, 1'b0);

    // Error counter saturation
    for (int i = 0; i < 259; i++) begin
      do_req(1'b0, 3'd7, 15'h0000, 32'h0, 32'h0, 1'b1);
    end
    idle(2);
    chk("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
    chk("err_cnt_model", {24'b0, err_cnt}, exp_errcnt);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, byte-address width; memory depth is 2**(ADDR_W-2) 32-bit words.
REQ-002 SHALL have parameter ERR_CNT_W, default 8, width of the error counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when high together with req_valid at a rising edge.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_memop  input  3  0 = byte signed, 1 = half signed, 2 = word, 4 = byte unsigned, 5 = half unsigned.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  response consumed when high with rsp_valid at a rising edge.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended per memop.
REQ-014 SHALL have port rsp_err  output  1  request rejected.
REQ-015 SHALL have port err_cnt  output  ERR_CNT_W  count of rejected requests.

Function
REQ-016 SHALL drive req_ready = !rsp_valid || rsp_ready (combinational; at most one outstanding response).
REQ-017 SHALL complete every accepted request, load or store, with exactly one response asserted on the edge following acceptance (latency 1).
REQ-018 SHALL hold rsp_valid, rsp_rdata and rsp_err stable while rsp_valid && !rsp_ready.
REQ-019 SHALL, when a response is consumed and no new request is accepted on that edge, clear rsp_valid; a consumption and an acceptance on the same edge SHALL load the new response back-to-back.
REQ-020 SHALL place byte lanes little-endian: word index addr[ADDR_W-1:2], lane offset addr[1:0].
REQ-021 SHALL for loads return: memop 0/4 lane byte sign-/zero-extended; memop 1/5 halfword at offset 0 or 2 sign-/zero-extended; memop 2 full word.
REQ-022 SHALL for stores write only the addressed lanes via byte enables: memop 0 one lane, memop 1 two lanes, memop 2 four lanes, taking data from req_wdata low bits; other lanes unchanged.
REQ-023 SHALL perform the store write on the acceptance edge; a load accepted on the next edge to the same word SHALL return the new data.
REQ-024 SHALL reject (rsp_err = 1, rsp_rdata = 0, memory unchanged): memop 3, 6, 7; store with memop 4 or 5; halfword with addr[0] = 1; word with addr[1:0] != 0.
REQ-025 SHALL return rsp_err = 0 and rsp_rdata = 0 for a successful store.
REQ-026 SHALL increment err_cnt by one per rejected request, saturating at all-ones.
REQ-027 SHALL ignore req_we, req_memop, req_addr and req_wdata when the request is not accepted.

Reset
REQ-028 SHALL on rst_n low immediately force rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, err_cnt = 0.
REQ-029 SHALL discard a pending response on reset and SHALL not perform any store while rst_n is low.
REQ-030 SHALL not reset memory contents; contents before the first store are undefined.
REQ-031 SHALL keep req_ready = 1 while in reset (rsp_valid = 0), but SHALL accept no request until rst_n is high.

Verification
REQ-032 Store word 0x8000_00F1 at 0x0010, then load memop 0 at 0x0010 -> rsp_rdata 0xFFFF_FFF1 one cycle after acceptance; memop 4 -> 0x0000_00F1.
REQ-033 Store byte 0xAB at 0x0013 over word 0x1122_3344 at 0x0010, load word -> 0xAB22_3344; load memop 5 at 0x0012 -> 0x0000_AB22.
REQ-034 Load word at 0x0006 and store memop 4 at 0x0000 -> both rsp_err = 1, rsp_rdata 0, memory unchanged, err_cnt 0 -> 2.
REQ-035 Hold rsp_ready = 0 for 3 cycles with req_valid high -> req_ready = 0, response stable, no second acceptance; raise rsp_ready -> next request accepted on that same edge, back-to-back.
REQ-036 Assert rst_n low while rsp_valid = 1 and a store is presented -> rsp_valid drops immediately, store target word reads unchanged after reset.
REQ-037 Force 2**ERR_CNT_W + 3 rejected requests -> err_cnt saturates at all-ones.
